// File: rtl/roman_pkg.sv
// Shared symbol codes, ASCII constants and FSM states
// for the Roman numeral character path.
package roman_pkg;

  localparam logic [2:0] SYM_NULL = 3'd0;
  localparam logic [2:0] SYM_I    = 3'd1;
  localparam logic [2:0] SYM_V    = 3'd2;
  localparam logic [2:0] SYM_X    = 3'd3;
  localparam logic [2:0] SYM_L    = 3'd4;

  localparam logic [7:0] CH_I = 8'h49;
  localparam logic [7:0] CH_V = 8'h56;
  localparam logic [7:0] CH_X = 8'h58;
  localparam logic [7:0] CH_L = 8'h4C;
  localparam logic [7:0] CH_Q = 8'h3F;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ZERO,
    EOL
  } state_t;

endpackage

// File: rtl/roman_char_streamer_if.sv
// Word-in / character-out handshake bundle
// of the Roman character streamer.
interface roman_char_streamer_if #(
  parameter int W = 3,
  parameter int N = 6
);

  logic         in_valid;
  logic         in_ready;
  logic [W*N-1:0] in_sym;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_char;
  logic         out_last;
  logic         err;

  modport master (
    output in_valid, in_sym, out_ready,
    input  in_ready, out_valid, out_char,
    input  out_last, err
  );

  modport slave (
    input  in_valid, in_sym, out_ready,
    output in_ready, out_valid, out_char,
    output out_last, err
  );

endinterface

// File: rtl/roman_sym2ascii.sv
// Maps one Roman symbol code to its ASCII
// character; undefined codes become '?'.
module roman_sym2ascii
  import roman_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] code,
  output logic [7:0]   ch
);

  always_comb begin
    ch = CH_Q;
    unique case (1'b1)
      code == W'(SYM_I): ch = CH_I;
      code == W'(SYM_V): ch = CH_V;
      code == W'(SYM_X): ch = CH_X;
      code == W'(SYM_L): ch = CH_L;
      default:           ch = CH_Q;
    endcase
  end

endmodule

// File: rtl/roman_char_streamer.sv
// Streams a packed six-slot Roman symbol word
// as ASCII characters, one per handshake.
module roman_char_streamer
  import roman_pkg::*;
#(
  parameter int         OUT_WIDTH = 3,
  parameter int         OUT_NUM   = 6,
  parameter bit         EOL_EN    = 1'b1,
  parameter logic [7:0] EOL_CHAR  = 8'h0A,
  parameter logic [7:0] ZERO_CHAR = 8'h4E
) (
  input logic clk,
  input logic rst,
  roman_char_streamer_if.slave bus
);

  localparam int SW = OUT_WIDTH * OUT_NUM;

  state_t               state_q, state_d;
  logic [OUT_NUM-1:0]   mask_q, mask_d;
  logic [OUT_NUM-1:0]   in_mask;
  logic [SW-1:0]        sym_q, sym_d;
  logic                 err_q, err_d, in_err;
  logic                 vld_q, vld_d;
  logic                 last_q, last_d;
  logic [7:0]           char_q, char_d;
  logic [7:0]           sel_ch;
  logic [OUT_WIDTH-1:0] sel_code;
  logic                 acc, fire;

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign acc           = bus.in_valid && bus.in_ready;
  assign fire          = vld_q && bus.out_ready;
  assign bus.out_valid = vld_q;
  assign bus.out_char  = char_q;
  assign bus.out_last  = last_q;
  assign bus.err       = err_q;

  always_comb begin : scan_in
    in_mask = '0;
    in_err  = 1'b0;
    for (int k = 0; k < OUT_NUM; k++) begin
      in_mask[k] = bus.in_sym[OUT_WIDTH*(OUT_NUM-1-k) +: OUT_WIDTH] != '0;
      if (bus.in_sym[OUT_WIDTH*(OUT_NUM-1-k) +: OUT_WIDTH] > OUT_WIDTH'(SYM_L))
        in_err = 1'b1;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    mask_d  = mask_q;
    sym_d   = sym_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (acc) begin
        sym_d   = bus.in_sym;
        mask_d  = in_mask;
        err_d   = in_err;
        state_d = (in_mask == '0) ? ZERO : SEND;
      end
      SEND: if (fire) begin
        // Drop the slot just sent: the lowest set bit.
        mask_d = mask_q & (mask_q - OUT_NUM'(1));
        if (mask_d == '0)
          state_d = EOL_EN ? EOL : IDLE;
      end
      ZERO: if (fire)
        state_d = EOL_EN ? EOL : IDLE;
      EOL: if (fire)
        state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so look at the slot the next state will show.
  always_comb begin : pick_slot
    sel_code = '0;
    for (int k = OUT_NUM - 1; k >= 0; k--)
      if (mask_d[k])
        sel_code = sym_d[OUT_WIDTH*(OUT_NUM-1-k) +: OUT_WIDTH];
  end

  roman_sym2ascii #(
    .W (OUT_WIDTH)
  ) u_map (
    .code (sel_code),
    .ch   (sel_ch)
  );

  always_comb begin : next_out
    vld_d  = 1'b0;
    char_d = '0;
    last_d = 1'b0;
    unique case (state_d)
      SEND: begin
        vld_d  = 1'b1;
        char_d = sel_ch;
        last_d = !EOL_EN &&
                 ((mask_d & (mask_d - OUT_NUM'(1))) == '0);
      end
      ZERO: begin
        vld_d  = 1'b1;
        char_d = ZERO_CHAR;
        last_d = !EOL_EN;
      end
      EOL: begin
        vld_d  = 1'b1;
        char_d = EOL_CHAR;
        last_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      sym_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      char_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      sym_q   <= sym_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      char_q  <= char_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_roman_char_streamer.sv
// Self-checking bench for roman_char_streamer with
// EOL enabled and disabled instances.
module tb_roman_char_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [17:0] in_sym = '0;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  bit         exp_err;

  roman_char_streamer_if #(.W(3), .N(6)) b0 ();
  roman_char_streamer_if #(.W(3), .N(6)) b1 ();

  roman_char_streamer #(.EOL_EN(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  roman_char_streamer #(.EOL_EN(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  assign b0.in_valid  = in_valid & ~sel;
  assign b1.in_valid  = in_valid & sel;
  assign b0.in_sym    = in_sym;
  assign b1.in_sym    = in_sym;
  assign b0.out_ready = out_ready;
  assign b1.out_ready = out_ready;

  logic       o_valid, o_in_ready, o_last, o_err;
  logic [7:0] o_char;
  assign o_valid    = sel ? b1.out_valid : b0.out_valid;
  assign o_in_ready = sel ? b1.in_ready  : b0.in_ready;
  assign o_last     = sel ? b1.out_last  : b0.out_last;
  assign o_err      = sel ? b1.err       : b0.err;
  assign o_char     = sel ? b1.out_char  : b0.out_char;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] sym;
    bit          eol;
    bit          hold;
    logic [2:0]  n;
    logic [39:0] ch;
    bit          err;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected character stream straight from the symbol rules.
  task automatic build_model(input logic [17:0] sym, input bit e);
    logic [2:0] c;
    exp_q.delete();
    exp_err = 1'b0;
    for (int k = 0; k < 6; k++) begin
      c = sym[3*(5-k) +: 3];
      if (c > 3'd4) exp_err = 1'b1;
      case (c)
        3'd0: ;
        3'd1: exp_q.push_back(8'h49);
        3'd2: exp_q.push_back(8'h56);
        3'd3: exp_q.push_back(8'h58);
        3'd4: exp_q.push_back(8'h4C);
        default: exp_q.push_back(8'h3F);
      endcase
    end
    if (exp_q.size() == 0) exp_q.push_back(8'h4E);
    if (e) exp_q.push_back(8'h0A);
  endtask

  task automatic run_word(input logic [17:0] sym, input bit e,
                          input int stall_pct, input bit hold2);
    logic [7:0] got[$];
    logic [7:0] pc = '0;
    logic       pl = 1'b0;
    bit was_stall = 0;
    bit done = 0;
    int n = 0;
    int stall = 0;
    int t = 0;
    sel = e;
    while (!o_in_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    check("accept_ready", o_in_ready, 1);
    in_valid = 1'b1;
    in_sym = sym;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("err_after_accept", o_err, exp_err);
    check("busy_ready", o_in_ready, 0);
    t = 0;
    while (!done && t < 60) begin
      if (was_stall)
        check("hold", {o_valid, o_char, o_last}, {1'b1, pc, pl});
      else
        check("busy_valid", o_valid, 1);
      if (hold2 && n == 1 && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end else
        out_ready = ($urandom_range(0, 99) >= stall_pct);
      in_valid = !o_last && ($urandom_range(0, 1) == 1);
      in_sym = 18'($urandom);
      if (o_valid && out_ready) begin
        got.push_back(o_char);
        check("last_flag", o_last, n == exp_q.size() - 1);
        if (o_last) done = 1;
        n++;
        was_stall = 0;
      end else begin
        was_stall = o_valid;
        pc = o_char;
        pl = o_last;
      end
      @(posedge clk); #1; t++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("word_done", done, 1);
    if (stall_pct == 0 && !hold2)
      check("cycles", t, exp_q.size());
    check("n_chars", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check("char", got[i], exp_q[i]);
    check("ready_after", o_in_ready, 1);
    check("idle_valid", o_valid, 0);
    check("err_hold", o_err, exp_err);
  endtask

  initial begin
    logic [17:0] rs;
    bit re;

    vt[0] = '{18'h1C2C0, 1'b1, 1'b0, 3'd5,
              {8'h58, 8'h4C, 8'h49, 8'h58, 8'h0A}, 1'b0};
    vt[1] = '{18'h09200, 1'b0, 1'b0, 3'd3,
              {8'h49, 8'h49, 8'h49, 8'h00, 8'h00}, 1'b0};
    vt[2] = '{18'h00000, 1'b1, 1'b0, 3'd2,
              {8'h4E, 8'h0A, 8'h00, 8'h00, 8'h00}, 1'b0};
    vt[3] = '{18'h09E00, 1'b1, 1'b0, 3'd4,
              {8'h49, 8'h49, 8'h3F, 8'h0A, 8'h00}, 1'b1};
    vt[4] = '{18'h00000, 1'b0, 1'b0, 3'd1,
              {8'h4E, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b0};
    vt[5] = '{18'h02103, 1'b1, 1'b0, 3'd4,
              {8'h56, 8'h4C, 8'h58, 8'h0A, 8'h00}, 1'b0};
    vt[6] = '{18'h1C2C0, 1'b1, 1'b1, 3'd5,
              {8'h58, 8'h4C, 8'h49, 8'h58, 8'h0A}, 1'b0};
    vt[7] = '{18'h09E00, 1'b0, 1'b0, 3'd3,
              {8'h49, 8'h49, 8'h3F, 8'h00, 8'h00}, 1'b1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_valid", o_valid, 0);
      check("rst_char", o_char, 0);
      check("rst_last", o_last, 0);
      check("rst_err", o_err, 0);
      check("rst_ready", o_in_ready, 0);
    end
    rst = 1'b0;
    #1;
    check("ready_post_rst", o_in_ready, 1);

    foreach (vt[i]) begin
      exp_q.delete();
      for (int j = 0; j < vt[i].n; j++)
        exp_q.push_back(vt[i].ch[8*(4-j) +: 8]);
      exp_err = vt[i].err;
      run_word(vt[i].sym, vt[i].eol, 0, vt[i].hold);
    end

    // Reset in the middle of a word.
    sel = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_sym = 18'h1C2C0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_last", o_last, 0);
    check("midrst_ready", o_in_ready, 0);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", o_in_ready, 1);
    build_model(18'h09200, 1'b1);
    run_word(18'h09200, 1'b1, 0, 1'b0);

    // Reset coincident with an input handshake.
    in_valid = 1'b1;
    in_sym = 18'h1C2C0;
    rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    check("rst_vs_accept_valid", o_valid, 0);
    @(posedge clk); #1;
    check("rst_vs_accept_idle", o_valid, 0);

    for (int w = 0; w < 40; w++) begin
      rs = '0;
      if ($urandom_range(0, 9) != 0)
        for (int k = 0; k < 6; k++)
          rs[3*k +: 3] = ($urandom_range(0, 9) < 3) ?
                         3'd0 : 3'($urandom_range(1, 7));
      re = 1'($urandom_range(0, 1));
      build_model(rs, re);
      run_word(rs, re, 30, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/roman_char_streamer.md
# roman_char_streamer

Downstream consumer of the binary-to-Roman converter. Accepts one packed six-slot Roman symbol word per valid/ready handshake and streams it out as ASCII characters, one per handshake, skipping NULL slots. It appends an optional end-of-line character and feeds a byte-wide sink such as a UART transmitter or a character display buffer.

## Interface
Parameters:
- OUT_WIDTH, 3, bits per symbol code
- OUT_NUM, 6, symbol slots per word
- EOL_EN, 1, 1 = append EOL_CHAR after each word
- EOL_CHAR, 8'h0A, terminator character
- ZERO_CHAR, 8'h4E ('N'), emitted for an all-NULL word

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  symbol word valid
- in_ready  out  1  block can accept a word
- in_sym  in  OUT_WIDTH*OUT_NUM  slot 0 in the MSBs (bits 17:15), slot 5 in the LSBs
- out_valid  out  1  out_char valid
- out_ready  in  1  sink accepts out_char
- out_char  out  8  ASCII character
- out_last  out  1  final character of the current word
- err  out  1  latched word contained an undefined code (5..7)

## Operation
- Symbol codes: 0 NULL, 1 I (0x49), 2 V (0x56), 3 X (0x58), 4 L (0x4C), 5..7 undefined and emitted as '?' (0x3F).
- States:
  - IDLE: in_ready=1. On in_valid, latch in_sym and build pend_mask[OUT_NUM-1:0], where bit k = (slot k != NULL).
  - If the mask is zero, go to ZERO. Otherwise go to SEND.
  - ERR is set to 1 if any slot code is greater than 4, else 0. It holds until the next acceptance.
- SEND: the current slot is the lowest-index set bit of pend_mask (slot 0 first). Output its ASCII char.
  - On an out handshake, clear that bit.
  - If no bits remain, go to EOL when EOL_EN=1, else to IDLE.
- ZERO: emit ZERO_CHAR. On handshake, go to EOL (EOL_EN=1) or IDLE.
- EOL: emit EOL_CHAR. On handshake, go to IDLE.
- NULL slots between non-NULL slots are skipped silently; order is preserved.
- out_last is 1 on the last character of the word: EOL_CHAR if EOL_EN=1, else the last symbol or ZERO_CHAR.
- out_valid, out_char, and out_last are registered outputs. They hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: in_ready=0 while rst=1, then 1 in the first cycle after reset; out_valid=0, out_char=8'h00, out_last=0, err=0; state=IDLE; mask=0.
- Input acceptance at edge t gives out_valid=1 with the first char from cycle t+1.
- One character per cycle while out_ready=1.
- A word producing k chars occupies k cycles. in_ready rises the cycle after the final out handshake, so there is no overlap or bypass.
- in_ready=0 in all states except IDLE, and in_sym is ignored then.
- Reset mid-word: the word is discarded, out_valid=0 next cycle, and no partial out_last is issued.
- Simultaneous rst with either handshake: rst wins.

## Structure
- The shared package roman_pkg holds:
  - SYM_NULL/I/V/X/L codes (matching the converter's parameters);
  - ASCII constants CH_I, CH_V, CH_X, CH_L, CH_Q;
  - the state enum {IDLE, SEND, ZERO, EOL}.
- The sub-module roman_sym2ascii is combinational, mapping a 3-bit code to 8-bit ASCII with the '?' default. It is instantiated once on the selected slot.
- The lowest-set-bit priority encoder over pend_mask stays inline.

## Test plan
- Value 49: in_sym=18'h1C2C0 (X,L,I,X,NULL,NULL), out_ready=1 → chars 58,4C,49,58,0A on consecutive cycles; out_last only on 0A; in_ready high one cycle later.
- Value 3: in_sym=18'h09200 (I,I,I) with EOL_EN=0 → 49,49,49; out_last on the third 49.
- All-NULL: in_sym=0 → 4E then 0A; err=0.
- Backpressure: word 18'h1C2C0 with out_ready low for 3 cycles on the second char → 4C held stable with out_valid=1; total 5 chars, no loss or duplication.
- Undefined code: slot 2 = 3'b111 with slots 0 and 1 = I → 49,49,3F,0A; err=1 from the cycle after acceptance until the next acceptance.
- Reset mid-stream: rst asserted after the 2nd char of 49 → out_valid=0 next cycle; new word 18'h09200 afterwards → clean 49,49,49,0A.
